// File: rtl/four_way_demux_router.sv
`timescale 1ns/1ps
// Four-way demultiplexing router: steers one word stream into four independent
// destination FIFOs, the destination chosen per word by in_op.

module four_way_demux_router_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop_req,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             valid,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             pop;

    assign valid = (count != '0);
    assign full  = (count == CW'(DEPTH));
    // A pop request on an empty FIFO is ignored, so nothing can underflow.
    assign pop   = valid & pop_req;
    // Head is masked while empty so a consumer never sees a stale word.
    assign head  = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is gated by the occupancy count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end
endmodule

module four_way_demux_router #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [CW-1:0]    count0,
    output logic [CW-1:0]    count1,
    output logic [CW-1:0]    count2,
    output logic [CW-1:0]    count3,
    output logic             busy
);
    logic [3:0]       full;
    logic [WIDTH-1:0] head [4];
    logic [CW-1:0]    cnt  [4];

    // Readiness depends only on the selected FIFO's fullness, never on
    // out_ready: a full FIFO does not accept even if it pops this cycle.
    assign in_ready = ~full[in_op];

    for (genvar i = 0; i < 4; i++) begin : g_ch
        logic push;
        assign push = in_valid & in_ready & (in_op == 2'(i));

        four_way_demux_router_fifo #(
            .WIDTH(WIDTH),
            .DEPTH(DEPTH),
            .CW   (CW)
        ) u_fifo (
            .clk    (clk),
            .reset  (reset),
            .push   (push),
            .pop_req(out_ready[i]),
            .wdata  (in_data),
            .full   (full[i]),
            .valid  (out_valid[i]),
            .head   (head[i]),
            .count  (cnt[i])
        );
    end

    assign out0   = head[0];
    assign out1   = head[1];
    assign out2   = head[2];
    assign out3   = head[3];
    assign count0 = cnt[0];
    assign count1 = cnt[1];
    assign count2 = cnt[2];
    assign count3 = cnt[3];
    assign busy   = |out_valid;
endmodule
